// File: rtl/commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buf
// Purpose  : Captures the retirement stream of the single-cycle CPU into a
//            FIFO and streams the records out over a valid/ready port. Capture
//            is armed by start and ends when the halt PC commits or the commit
//            limit is reached. The done flag rises once the FIFO has drained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           one-cycle pulse; arms capture from IDLE or DONE
//   commit_*        retirement record: valid, pc, instr, we, rd, wdata
//   trace_valid     trace_data holds a record (registered)
//   trace_ready     consumer accepts the record this cycle
//   trace_data      {pc[101:70], instr[69:38], we[37], rd[36:32], wdata[31:0]}
//   count           commits accepted since the last start (saturating)
//   overflow        sticky: a commit was dropped because the FIFO was full
//   done            capture ended and the FIFO has drained
// ============================================================================
module commit_trace_buf #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] HALT_PC     = 32'h0000_0198,
  parameter int          MAX_COMMITS = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          commit_valid,
  input  logic [31:0]   commit_pc,
  input  logic [31:0]   commit_instr,
  input  logic          commit_we,
  input  logic [4:0]    commit_rd,
  input  logic [31:0]   commit_wdata,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [101:0]  trace_data,
  output logic [15:0]   count,
  output logic          overflow,
  output logic          done
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] MAX_C   = MAX_COMMITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [15:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           trace_valid_q, trace_valid_d;
  logic [101:0]   trace_data_q, trace_data_d;
  logic [101:0]   mem_q [DEPTH];

  logic           w_full;
  logic           w_pop;
  logic           w_push_req;
  logic           w_push_acc;
  logic [101:0]   w_rec;

  assign w_rec  = {commit_pc, commit_instr, commit_we, commit_rd, commit_wdata};
  assign w_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop  = trace_valid_q && trace_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    trace_valid_d = trace_valid_q;
    trace_data_d  = trace_data_q;

    w_push_req = (state_q == ST_RUN) && commit_valid;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    w_push_acc = w_push_req && (!w_full || w_pop);

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (w_push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
    if (w_push_req && !w_push_acc) begin
      overflow_d = 1'b1;
    end

    // The output register looks only at entries written before this edge, so
    // a record pushed now is presented one cycle later at the earliest. The
    // head entry is never overwritten while it is presented, which keeps
    // trace_data stable under backpressure.
    trace_valid_d = (rd_ptr_d != wr_ptr_q);
    if (trace_valid_d) begin
      trace_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          count_d    = 16'd0;
          overflow_d = 1'b0;
        end
      end
      ST_RUN: begin
        // A dropped halt commit still ends capture; the limit only counts
        // accepted commits.
        if (commit_valid &&
            ((commit_pc == HALT_PC) ||
             (w_push_acc && ({16'd0, count_d} == MAX_C)))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // No pushes here, so the FIFO is empty after this edge exactly when
        // the read pointer catches the write pointer.
        if (rd_ptr_d == wr_ptr_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          count_d    = 16'd0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= 16'd0;
      overflow_q    <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      trace_valid_q <= trace_valid_d;
      trace_data_q  <= trace_data_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= w_rec;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_data  = trace_data_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_buf
// Purpose  : Directed self-checking bench for commit_trace_buf. One instance
//            uses default parameters; a second uses MAX_COMMITS=4 for the
//            commit-limit exit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, cv, we, ready;
  logic [31:0]   pc, instr, wd;
  logic [4:0]    rd;
  logic          tv, ovf, dn;
  logic [101:0]  td;
  logic [15:0]   cnt;

  logic          l_start, l_cv, l_we, l_ready;
  logic [31:0]   l_pc, l_instr, l_wd;
  logic [4:0]    l_rd;
  logic          l_tv, l_ovf, l_dn;
  logic [101:0]  l_td;
  logic [15:0]   l_cnt;

  int n_run  = 0;
  int n_fail = 0;

  commit_trace_buf dut (
    .clk(clk), .rst(rst), .start(start),
    .commit_valid(cv), .commit_pc(pc), .commit_instr(instr),
    .commit_we(we), .commit_rd(rd), .commit_wdata(wd),
    .trace_valid(tv), .trace_ready(ready), .trace_data(td),
    .count(cnt), .overflow(ovf), .done(dn)
  );

  commit_trace_buf #(.MAX_COMMITS(4)) dut_lim (
    .clk(clk), .rst(rst), .start(l_start),
    .commit_valid(l_cv), .commit_pc(l_pc), .commit_instr(l_instr),
    .commit_we(l_we), .commit_rd(l_rd), .commit_wdata(l_wd),
    .trace_valid(l_tv), .trace_ready(l_ready), .trace_data(l_td),
    .count(l_cnt), .overflow(l_ovf), .done(l_dn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return p ^ 32'hA5A5_0013;
  endfunction

  function automatic logic [101:0] rec(input logic [31:0] p, input logic [31:0] i,
                                       input logic w, input logic [4:0] r,
                                       input logic [31:0] d);
    return {p, i, w, r, d};
  endfunction

  function automatic logic [101:0] exp_of(input logic [31:0] p);
    return rec(p, instr_of(p), p[2], p[6:2], ~p);
  endfunction

  task automatic drive(input logic [31:0] p, input logic w, input logic [4:0] r,
                       input logic [31:0] d);
    cv = 1'b1; pc = p; instr = instr_of(p); we = w; rd = r; wd = d;
  endtask

  task automatic drive_bulk(input logic [31:0] p);
    drive(p, p[2], p[6:2], ~p);
  endtask

  task automatic drive_l(input logic [31:0] p);
    l_cv = 1'b1; l_pc = p; l_instr = instr_of(p); l_we = p[2]; l_rd = p[6:2]; l_wd = ~p;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cv = 1'b0; we = 1'b0; ready = 1'b0;
    pc = '0; instr = '0; wd = '0; rd = '0;
    l_start = 1'b0; l_cv = 1'b0; l_we = 1'b0; l_ready = 1'b0;
    l_pc = '0; l_instr = '0; l_wd = '0; l_rd = '0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 128'(tv), 128'(0));
    chk("rst_data",  128'(td), 128'(0));
    chk("rst_count", 128'(cnt), 128'(0));
    chk("rst_ovf",   128'(ovf), 128'(0));
    chk("rst_done",  128'(dn), 128'(0));
    rst = 1'b0;
    tick();

    // T2 basic stream with ready held high
    start = 1'b1; tick(); start = 1'b0;
    ready = 1'b1;
    drive(32'h0, 1'b1, 5'd5, 32'd7); tick();
    chk("t2_latency_valid", 128'(tv), 128'(0));
    chk("t2_count1", 128'(cnt), 128'(1));
    drive(32'h4, 1'b1, 5'd5, 32'd7); tick();
    chk("t2_rec0_valid", 128'(tv), 128'(1));
    chk("t2_rec0", 128'(td), 128'(rec(32'h0, instr_of(32'h0), 1'b1, 5'd5, 32'd7)));
    drive(32'h8, 1'b1, 5'd5, 32'd7); tick();
    cv = 1'b0;
    chk("t2_rec1", 128'(td), 128'(rec(32'h4, instr_of(32'h4), 1'b1, 5'd5, 32'd7)));
    tick();
    chk("t2_rec2_valid", 128'(tv), 128'(1));
    chk("t2_rec2", 128'(td), 128'(rec(32'h8, instr_of(32'h8), 1'b1, 5'd5, 32'd7)));
    tick();
    chk("t2_empty_valid", 128'(tv), 128'(0));
    chk("t2_empty_hold", 128'(td), 128'(rec(32'h8, instr_of(32'h8), 1'b1, 5'd5, 32'd7)));
    chk("t2_count3", 128'(cnt), 128'(3));

    // T3 halt exit
    drive_bulk(32'h198); tick();
    chk("t3_done_early", 128'(dn), 128'(0));
    drive_bulk(32'h1C); tick();
    chk("t3_halt_valid", 128'(tv), 128'(1));
    chk("t3_halt_rec", 128'(td), 128'(exp_of(32'h198)));
    chk("t3_done_wait", 128'(dn), 128'(0));
    tick();
    chk("t3_done", 128'(dn), 128'(1));
    chk("t3_drained", 128'(tv), 128'(0));
    tick();
    cv = 1'b0;
    chk("t3_count_after_ignore", 128'(cnt), 128'(4));
    chk("t3_valid_after_ignore", 128'(tv), 128'(0));

    // T4 full FIFO with backpressure
    ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_count_cleared", 128'(cnt), 128'(0));
    chk("t4_done_cleared", 128'(dn), 128'(0));
    for (int i = 0; i < 18; i++) begin
      drive_bulk(32'(i * 4)); tick();
    end
    cv = 1'b0; tick();
    chk("t4_count16", 128'(cnt), 128'(16));
    chk("t4_overflow", 128'(ovf), 128'(1));
    chk("t4_held", 128'(td), 128'(exp_of(32'h0)));
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_valid", 128'(tv), 128'(1));
      chk("t4_rec", 128'(td), 128'(exp_of(32'(i * 4))));
      tick();
    end
    chk("t4_exactly16", 128'(tv), 128'(0));

    // T1 asynchronous reset mid-RUN with queued records
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_bulk(32'(32'h40 + i * 4)); tick();
    end
    cv = 1'b0; tick();
    chk("t1_queued", 128'(tv), 128'(1));
    rst = 1'b1; #1;
    chk("t1_async_valid", 128'(tv), 128'(0));
    chk("t1_async_count", 128'(cnt), 128'(0));
    chk("t1_async_ovf", 128'(ovf), 128'(0));
    chk("t1_async_data", 128'(td), 128'(0));
    tick(); rst = 1'b0;
    drive_bulk(32'h80); tick(); tick();
    cv = 1'b0;
    chk("t1_idle_ignores", 128'(cnt), 128'(0));
    chk("t1_idle_valid", 128'(tv), 128'(0));
    start = 1'b1; tick(); start = 1'b0;

    // T5 push and pop in the same cycle on a full FIFO
    for (int i = 0; i < 16; i++) begin
      drive_bulk(32'(32'h100 + i * 4)); tick();
    end
    cv = 1'b0; tick();
    chk("t5_count16", 128'(cnt), 128'(16));
    chk("t5_no_ovf", 128'(ovf), 128'(0));
    chk("t5_head", 128'(td), 128'(exp_of(32'h100)));
    ready = 1'b1;
    drive_bulk(32'h200); tick();
    cv = 1'b0;
    chk("t5_count17", 128'(cnt), 128'(17));
    chk("t5_ovf_stays0", 128'(ovf), 128'(0));
    for (int i = 1; i < 16; i++) begin
      chk("t5_rec", 128'(td), 128'(exp_of(32'(32'h100 + i * 4))));
      tick();
    end
    chk("t5_last_rec", 128'(td), 128'(exp_of(32'h200)));
    tick();
    chk("t5_empty", 128'(tv), 128'(0));

    // T6 commit limit on the MAX_COMMITS=4 instance
    l_start = 1'b1; tick(); l_start = 1'b0;
    l_ready = 1'b1;
    drive_l(32'h0); tick();
    chk("t6_latency", 128'(l_tv), 128'(0));
    chk("t6_count1", 128'(l_cnt), 128'(1));
    drive_l(32'h4); tick();
    chk("t6_rec0", 128'(l_td), 128'(exp_of(32'h0)));
    drive_l(32'h8); tick();
    chk("t6_rec1", 128'(l_td), 128'(exp_of(32'h4)));
    drive_l(32'hC); tick();
    chk("t6_rec2", 128'(l_td), 128'(exp_of(32'h8)));
    chk("t6_count4", 128'(l_cnt), 128'(4));
    chk("t6_not_done", 128'(l_dn), 128'(0));
    drive_l(32'h10); tick();
    chk("t6_rec3", 128'(l_td), 128'(exp_of(32'hC)));
    drive_l(32'h14); tick();
    l_cv = 1'b0;
    chk("t6_drained", 128'(l_tv), 128'(0));
    chk("t6_done", 128'(l_dn), 128'(1));
    chk("t6_count_limit", 128'(l_cnt), 128'(4));
    l_start = 1'b1; tick(); l_start = 1'b0;
    chk("t6_rearm_count", 128'(l_cnt), 128'(0));
    chk("t6_rearm_done", 128'(l_dn), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
